// File: rtl/dsp_mul_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the shared-DSP arbiter.
// The arbiter takes the slave view; clients plus the multiplier take the master view.
interface dsp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  logic                     hold;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [WIDTH-1:0]         mul_p;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_p;
  logic                     busy;

  modport master (
    output hold, req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, resp_valid, resp_p, busy
  );

  modport slave (
    input  hold, req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, resp_valid, resp_p, busy
  );
endinterface

// File: rtl/dsp_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier among NUM_REQ clients.
// A tag pipeline as deep as the multiplier routes each product back to its issuer.
module dsp_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int PIPE_DEPTH = 0
) (
  input logic             clk,
  input logic             rst_n,
  dsp_mul_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_next;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  logic               issue_valid;
  logic [ID_W-1:0]    issue_id;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;

  logic               last_valid;
  logic [ID_W-1:0]    last_id;
  logic               tag_busy;
  logic [NUM_REQ-1:0] resp_valid_c;

  // Search starts at ptr and wraps; grants are suppressed during hold and reset.
  always_comb begin : grant_search
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    grant       = '0;
    sel_a       = '0;
    sel_b       = '0;
    idx         = 0;
    if (rst_n && !bus.hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!grant_found && bus.req_valid[idx]) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(idx);
          grant[idx]  = 1'b1;
          sel_a       = bus.req_a[idx*WIDTH +: WIDTH];
          sel_b       = bus.req_b[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign ptr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  // Operands only move on a transfer so the multiplier inputs stay quiet when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      issue_valid <= 1'b0;
      issue_id    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      issue_valid <= grant_found;
      if (grant_found) begin
        ptr      <= ptr_next;
        issue_id <= grant_id;
        mul_a_q  <= sel_a;
        mul_b_q  <= sel_b;
      end
    end
  end

  if (PIPE_DEPTH > 0) begin : g_pipe
    logic [PIPE_DEPTH-1:0] pipe_valid;
    logic [ID_W-1:0]       pipe_id [PIPE_DEPTH];

    // Tags never stall: the multiplier has no back-pressure.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= issue_valid;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
          pipe_valid[s] <= pipe_valid[s-1];
        end
      end
      pipe_id[0] <= issue_id;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        pipe_id[s] <= pipe_id[s-1];
      end
    end

    assign last_valid = pipe_valid[PIPE_DEPTH-1];
    assign last_id    = pipe_id[PIPE_DEPTH-1];
    assign tag_busy   = |pipe_valid;
  end else begin : g_nopipe
    assign last_valid = issue_valid;
    assign last_id    = issue_id;
    assign tag_busy   = 1'b0;
  end

  // Reset discards in-flight work, including a tag surfacing in the reset cycle.
  always_comb begin
    resp_valid_c = '0;
    if (rst_n && last_valid) begin
      resp_valid_c[last_id] = 1'b1;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_p     = bus.mul_p;
  assign bus.busy       = rst_n & (issue_valid | tag_busy);
endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Bench for dsp_mul_arbiter: three instances (depth 0, 2, 3) share one stimulus stream
// and are checked against a cycle-history model of grants, responses and busy.
module tb_dsp_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int HIST    = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;

  always #5 clk = ~clk;

  dsp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus0 ();
  dsp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus2 ();
  dsp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus3 ();

  assign bus0.hold = hold;  assign bus0.req_valid = req_valid;
  assign bus0.req_a = req_a; assign bus0.req_b = req_b;
  assign bus2.hold = hold;  assign bus2.req_valid = req_valid;
  assign bus2.req_a = req_a; assign bus2.req_b = req_b;
  assign bus3.hold = hold;  assign bus3.req_valid = req_valid;
  assign bus3.req_a = req_a; assign bus3.req_b = req_b;

  // External multipliers of depth 0, 2 and 3.
  logic [15:0] m2 [2];
  logic [15:0] m3 [3];
  assign bus0.mul_p = bus0.mul_a * bus0.mul_b;
  always_ff @(posedge clk) begin
    m2[0] <= bus2.mul_a * bus2.mul_b;
    m2[1] <= m2[0];
    m3[0] <= bus3.mul_a * bus3.mul_b;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign bus2.mul_p = m2[1];
  assign bus3.mul_p = m3[2];

  dsp_mul_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .PIPE_DEPTH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  dsp_mul_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .PIPE_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  dsp_mul_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .PIPE_DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = -1;
  int          ptr_m = 0;
  int          last_grant = -1;
  logic [15:0] exp_mul_a = '0;
  logic [15:0] exp_mul_b = '0;

  // History of what happened in each cycle, from which responses are derived.
  bit          xfer_valid [HIST];
  int          xfer_id    [HIST];
  logic [15:0] xfer_p     [HIST];
  bit          rst_low    [HIST];

  typedef struct {
    bit          hold;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  exp_ready;
  } vec_t;
  vec_t tbl [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit hd, input logic [3:0] v,
                               input logic [63:0] a, input logic [63:0] b);
    @(posedge clk);
    #1;
    rst_n     = rst;
    hold      = hd;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    cyc++;
  endtask

  function automatic int modelGrant();
    if (!rst_n || hold) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr_m + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // An op transferred in cycle k survives to cycle c unless reset was low in between.
  function automatic bit alive(input int k, input int c);
    if (k < 0) return 1'b0;
    if (!xfer_valid[k]) return 1'b0;
    for (int r = k + 1; r <= c; r++) begin
      if (rst_low[r]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkDut(input string tag, input int pd, input logic [3:0] rv,
                          input logic [15:0] rp, input logic bz);
    int         k;
    logic [3:0] erv;
    bit         eb;
    k   = cyc - 1 - pd;
    erv = 4'b0;
    if (alive(k, cyc)) erv = 4'(1 << xfer_id[k]);
    checkOutput({tag, "_resp_valid"}, 64'(rv), 64'(erv));
    if (erv != 4'b0) checkOutput({tag, "_resp_p"}, 64'(rp), 64'(xfer_p[k]));
    eb = 1'b0;
    for (int j = cyc - 1 - pd; j <= cyc - 1; j++) begin
      if (alive(j, cyc)) eb = 1'b1;
    end
    checkOutput({tag, "_busy"}, 64'(bz), 64'(eb));
  endtask

  task automatic evalCycle();
    int          g;
    logic [3:0]  er;
    logic [15:0] ag;
    logic [15:0] bg;
    logic [31:0] full;
    @(negedge clk);
    rst_low[cyc] = !rst_n;
    g  = modelGrant();
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    checkOutput("d0_req_ready", 64'(bus0.req_ready), 64'(er));
    checkOutput("d2_req_ready", 64'(bus2.req_ready), 64'(er));
    checkOutput("d3_req_ready", 64'(bus3.req_ready), 64'(er));
    checkOutput("d0_mul_a", 64'(bus0.mul_a), 64'(exp_mul_a));
    checkOutput("d0_mul_b", 64'(bus0.mul_b), 64'(exp_mul_b));
    checkOutput("d3_mul_a", 64'(bus3.mul_a), 64'(exp_mul_a));
    checkDut("d0", 0, bus0.resp_valid, bus0.resp_p, bus0.busy);
    checkDut("d2", 2, bus2.resp_valid, bus2.resp_p, bus2.busy);
    checkDut("d3", 3, bus3.resp_valid, bus3.resp_p, bus3.busy);
    last_grant      = g;
    xfer_valid[cyc] = (g >= 0);
    if (g >= 0) begin
      ag            = req_a[g*WIDTH +: WIDTH];
      bg            = req_b[g*WIDTH +: WIDTH];
      full          = ag * bg;
      xfer_id[cyc]  = g;
      xfer_p[cyc]   = full[15:0];
      exp_mul_a     = ag;
      exp_mul_b     = bg;
      ptr_m         = (g + 1) % NUM_REQ;
    end
    if (!rst_n) begin
      ptr_m     = 0;
      exp_mul_a = '0;
      exp_mul_b = '0;
    end
  endtask

  function automatic logic [63:0] packOps(input logic [15:0] base, input logic [15:0] step);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < NUM_REQ; j++) r[j*16 +: 16] = base + 16'(j) * step;
    return r;
  endfunction

  function automatic logic [15:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0]  pend_v;
    logic [63:0] pend_a;
    logic [63:0] pend_b;
    bit          hd;
    bit          rs;

    tbl[0]  = '{1'b0, 4'b1111, 16'hFFFF, 16'h0002, 4'b0001};
    tbl[1]  = '{1'b0, 4'b1111, 16'h1234, 16'h0101, 4'b0010};
    tbl[2]  = '{1'b0, 4'b1111, 16'h00FF, 16'h00FF, 4'b0100};
    tbl[3]  = '{1'b0, 4'b1111, 16'h8000, 16'h0003, 4'b1000};
    tbl[4]  = '{1'b0, 4'b1111, 16'h0007, 16'h0009, 4'b0001};
    tbl[5]  = '{1'b0, 4'b1111, 16'hABCD, 16'h0010, 4'b0010};
    tbl[6]  = '{1'b0, 4'b1111, 16'h0101, 16'h0101, 4'b0100};
    tbl[7]  = '{1'b0, 4'b1111, 16'h4000, 16'h0004, 4'b1000};
    tbl[8]  = '{1'b0, 4'b0100, 16'h0011, 16'h0022, 4'b0100};
    tbl[9]  = '{1'b1, 4'b1111, 16'h0033, 16'h0044, 4'b0000};
    tbl[10] = '{1'b1, 4'b1111, 16'h0033, 16'h0044, 4'b0000};
    tbl[11] = '{1'b0, 4'b1011, 16'h0033, 16'h0044, 4'b1000};
    tbl[12] = '{1'b0, 4'b0110, 16'h0055, 16'h0066, 4'b0010};
    tbl[13] = '{1'b0, 4'b0001, 16'h0077, 16'h0088, 4'b0001};
    tbl[14] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 4'b0000};
    tbl[15] = '{1'b0, 4'b1000, 16'h0F0F, 16'h0011, 4'b1000};

    // Reset: nothing granted even with every requester asking.
    applyStimulus(1'b0, 1'b0, 4'b1111, packOps(16'h0001, 16'h0001), packOps(16'h0002, 16'h0001));
    evalCycle();
    checkOutput("rst_req_ready", 64'(bus0.req_ready), 64'h0);
    applyStimulus(1'b0, 1'b0, 4'b1111, packOps(16'h0001, 16'h0001), packOps(16'h0002, 16'h0001));
    evalCycle();
    checkOutput("rst_busy", 64'(bus3.busy), 64'h0);
    checkOutput("rst_mul_a", 64'(bus0.mul_a), 64'h0);

    // Single op from requester 2 on the depth-0 instance.
    applyStimulus(1'b1, 1'b0, 4'b0100, {16'h0, 16'h0003, 16'h0, 16'h0}, {16'h0, 16'h0005, 16'h0, 16'h0});
    evalCycle();
    checkOutput("single_grant", 64'(bus0.req_ready), 64'h4);
    applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
    evalCycle();
    checkOutput("single_resp_valid", 64'(bus0.resp_valid), 64'h4);
    checkOutput("single_resp_p", 64'(bus0.resp_p), 64'h000F);
    checkOutput("single_busy", 64'(bus0.busy), 64'h1);
    applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
    evalCycle();
    checkOutput("single_busy_drop", 64'(bus0.busy), 64'h0);

    // Truncation on the depth-2 instance: 0xFFFF * 2 returns 3 cycles later.
    applyStimulus(1'b1, 1'b0, 4'b0001, {48'h0, 16'hFFFF}, {48'h0, 16'h0002});
    evalCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
      evalCycle();
    end
    checkOutput("trunc_resp_valid", 64'(bus2.resp_valid), 64'h1);
    checkOutput("trunc_resp_p", 64'(bus2.resp_p), 64'hFFFE);

    // Fairness, hold and wrap-around sequence from a fresh pointer.
    applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
    evalCycle();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, tbl[i].hold, tbl[i].valid, packOps(tbl[i].a, 16'h0001),
                    packOps(tbl[i].b, 16'h0003));
      evalCycle();
      checkOutput($sformatf("tbl_ready_%0d", i), 64'(bus0.req_ready), 64'(tbl[i].exp_ready));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
      evalCycle();
    end

    // Reset while two ops are in flight in the depth-3 instance.
    applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
    evalCycle();
    applyStimulus(1'b1, 1'b0, 4'b1111, packOps(16'h0100, 16'h0001), packOps(16'h0003, 16'h0001));
    evalCycle();
    applyStimulus(1'b1, 1'b0, 4'b1111, packOps(16'h0100, 16'h0001), packOps(16'h0003, 16'h0001));
    evalCycle();
    applyStimulus(1'b0, 1'b0, 4'b1111, packOps(16'h0100, 16'h0001), packOps(16'h0003, 16'h0001));
    evalCycle();
    checkOutput("midrst_ready", 64'(bus0.req_ready), 64'h0);
    applyStimulus(1'b1, 1'b0, 4'b1111, packOps(16'h0200, 16'h0001), packOps(16'h0005, 16'h0001));
    evalCycle();
    checkOutput("midrst_ptr_zero", 64'(bus0.req_ready), 64'h1);
    checkOutput("midrst_busy", 64'(bus3.busy), 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
      evalCycle();
      checkOutput($sformatf("midrst_no_resp_%0d", i), 64'(bus3.resp_valid), 64'h0);
    end

    // Random traffic; an ungranted requester keeps its request and operands.
    pend_v = '0;
    pend_a = '0;
    pend_b = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!(pend_v[j] && last_grant != j)) begin
          pend_v[j]         = ($urandom_range(0, 99) < 55);
          pend_a[j*16 +: 16] = randOperand();
          pend_b[j*16 +: 16] = randOperand();
        end
      end
      hd = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 499) != 0);
      applyStimulus(rs, hd, pend_v, pend_a, pend_b);
      evalCycle();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
      evalCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dsp_mul_arbiter.md
# dsp_mul_arbiter

Round-robin arbiter that shares one fixed-latency 16x16 multiplier (the DSP48E2-mapped `combinational_multiplier` or a pipelined variant) among `NUM_REQ` requesters. It sits between several client datapaths and a single DSP slice. It accepts at most one operand pair per cycle and registers the operands into the multiplier. A tag pipeline matched to the multiplier latency routes each product back to the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand and product width; the product is the low `WIDTH` bits of `a*b`.
- `PIPE_DEPTH`, 0: register stages inside the attached multiplier, 0..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `hold`  in  1  when high, no new grants are issued; in-flight operations complete.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant, one-hot or zero.
- `req_a`  in  `NUM_REQ*WIDTH`  operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `NUM_REQ*WIDTH`  operand B, packed the same way.
- `mul_a`  out  `WIDTH`  registered operand A to the multiplier.
- `mul_b`  out  `WIDTH`  registered operand B to the multiplier.
- `mul_p`  in  `WIDTH`  multiplier product, valid `PIPE_DEPTH` cycles after `mul_a`/`mul_b`.
- `resp_valid`  out  `NUM_REQ`  one-hot, single-cycle pulse to the owning requester.
- `resp_p`  out  `WIDTH`  product; equals `mul_p`; meaningful only while any `resp_valid` bit is high.
- `busy`  out  1  high while any accepted operation has not yet been returned.

## Operation
- **Grant**
  - Combinational round-robin search starts at pointer `ptr`.
  - `req_ready[i]` is 1 only for the first i (from `ptr`, wrapping modulo `NUM_REQ`) with `req_valid[i]=1`.
  - All `req_ready` bits are 0 when `hold=1` or `rst_n=0`.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - The requester must hold `req_a`/`req_b` stable while `req_valid` is high and ungranted.
- **Pointer**
  - On a transfer by i, `ptr <= (i+1) mod NUM_REQ`.
  - With no transfer, `ptr` holds.
  - A requester holding `req_valid` high is granted within `NUM_REQ` cycles (absent `hold`).
- **Issue register**
  - On a transfer, `mul_a`/`mul_b` latch the granted operands and the issue tag latches {valid=1, id=i}.
  - With no transfer, the tag valid bit clears and `mul_a`/`mul_b` hold their last values.
- **Tag pipeline**
  - `PIPE_DEPTH` stages of {valid, id}, advancing every cycle; there is no stall.
  - The multiplier never back-pressures, and requesters must accept responses; there is no response backpressure.
  - `resp_valid[id] = last_tag.valid`, where `last_tag` is the issue tag itself when `PIPE_DEPTH=0`.
  - `resp_p = mul_p`.
- **busy**: OR of all tag valid bits (issue tag plus pipeline stages).
- **Reset** (`rst_n=0` at an edge):
  - `ptr=0`, all tag valid bits 0, `mul_a=0`, `mul_b=0`.
  - Hence `resp_valid=0`, `busy=0`, `req_ready=0` while reset is asserted.
  - Operations in flight at reset are discarded; no response is ever produced for them.
- **hold** does not flush: operations accepted before `hold` rose still return normally.

## Timing
- Transfer at edge t; `mul_a`/`mul_b` are valid from t+1.
- `resp_valid` and `resp_p` are valid in the cycle starting at t+1+`PIPE_DEPTH`.
- Latency L = `PIPE_DEPTH`+1 cycles; throughput is 1 operation per cycle.
- Back-to-back transfers from different requesters produce back-to-back responses, in grant order.
- Simultaneous `req_valid` from all requesters, starting at `ptr=0`, grant 0,1,2,3,0,... on consecutive cycles.
- `hold` rising in cycle c blocks the grant in cycle c itself, because the grant is combinational.
- `rst_n` deasserted at edge t: the first grant is possible in the cycle after edge t.

## Test plan
- **Single op**: `PIPE_DEPTH=0`; requester 2 presents a=0x0003, b=0x0005 -> granted immediately; `resp_valid=4'b0100` and `resp_p=0x000F` exactly 1 cycle later; `busy` high for that 1 cycle.
- **Truncation**: `PIPE_DEPTH=2`; a=0xFFFF, b=0x0002 -> `resp_p=0xFFFE` exactly 3 cycles after the transfer.
- **Fairness**: all 4 `req_valid` held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses carry matching ids and products in the same order.
- **Hold**: accept one op, raise `hold` the next cycle with requests pending -> no grants while `hold` is high; the in-flight response still arrives at L; grants resume from the saved `ptr` when `hold` drops.
- **Reset mid-flight**: `PIPE_DEPTH=3`; two ops accepted, then `rst_n=0` for 1 cycle -> no `resp_valid` ever appears for them; `ptr=0`, `busy=0` after reset.
- **Random**: 10000 random valid/operand patterns checked against a scoreboard model -> every accepted op gets exactly one correct, correctly-routed response at latency L.
